// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding and wait-counter width.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_WAIT = 2'd1,
        MEMR_RESP = 2'd2
    } memr_state_e;

    // Wide enough for WAIT_CYCLES in 0..15
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Unified instruction+data word array: synchronous write, asynchronous read.
module mem_responder_mem_array #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing it would force flops instead of RAM,
    // and software expects contents to survive a core reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a request, waits WAIT_CYCLES, then strobes ready_o.
// Optional feature macro: MEM_RESP_ERRCHK_EN (reject misaligned / out-of-range addresses).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    memr_state_e      r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic             r_we;
    logic             r_err;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic             w_accept;
    logic             w_req_err;
    logic             w_resp;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_mem_rdata;
    logic             w_unused_addr;

    assign w_unused_addr = ^addr_i;

`ifdef MEM_RESP_ERRCHK_EN
    assign w_req_err = (addr_i[1:0] != 2'b00) || ((addr_i >> (IDX_W + 2)) != '0);
`else
    assign w_req_err = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            MEMR_IDLE: w_accept = req_i;
            MEMR_WAIT: begin
                if (r_cnt == '0) w_next_state = MEMR_RESP;
                else             w_next_cnt   = r_cnt - 1'b1;
            end
            MEMR_RESP: begin
                w_accept     = req_i;
                w_next_state = MEMR_IDLE;
            end
            default:   w_next_state = MEMR_IDLE;
        endcase
        if (w_accept) begin
            w_next_state = (WAIT_CYCLES > 0) ? MEMR_WAIT : MEMR_RESP;
            w_next_cnt   = CNT_INIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MEMR_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we    <= we_i;
                r_err   <= w_req_err;
                r_idx   <= addr_i[IDX_W+1:2];
                r_wdata <= wdata_i;
            end
            // Held read data only changes on a successful read response
            if (w_resp && !r_we && !r_err) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    assign w_resp   = (r_state == MEMR_RESP);
    assign w_mem_we = w_resp && r_we && !r_err;

    mem_responder_mem_array #(
        .WIDTH       (WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ready_o = w_resp;
    assign busy_o  = (r_state == MEMR_WAIT);
    assign err_o   = w_resp && r_err;

    always_comb begin
        rdata_o = r_rdata;
        if (w_resp && r_err)      rdata_o = '0;
        else if (w_resp && !r_we) rdata_o = w_mem_rdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with WAIT_CYCLES=1 (a) and one with WAIT_CYCLES=0 (b).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic        we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;
    logic        busy_b_seen = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_RESP_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata_a), .ready_o(ready_a), .busy_o(busy_a), .err_o(err_a)
    );

    mem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata_b), .ready_o(ready_b), .busy_o(busy_b), .err_o(err_b)
    );

    always @(posedge clk) if (busy_b) busy_b_seen <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, return read data, error flag and accept-to-ready latency.
    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        lat = 1;
        while (!(sel ? ready_b : ready_a) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? rdata_b : rdata_a;
        er = sel ? err_b : err_a;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        #12;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_err",   32'(err_a),   32'd0);
        check("rst_rdata", rdata_a,      32'd0);
        @(negedge clk); rst = 1'b1;

        // WAIT_CYCLES=1 write then read
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("w10_lat", 32'(lat), 32'd2);
        check("w10_err", 32'(er),  32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("r10_lat",  32'(lat), 32'd2);
        check("r10_data", rd,       32'hDEADBEEF);
        check("r10_err",  32'(er),  32'd0);

        // WAIT_CYCLES=0
        txn(1, 1'b1, 32'h0, 32'hCAFEF00D, rd, er, lat);
        check("b_w0_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("b_r0_lat",  32'(lat), 32'd1);
        check("b_r0_data", rd,       32'hCAFEF00D);

        // Back-to-back: write @0x20 then read @0x20 with req held through RESP
        @(negedge clk);
        req_a = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234;
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'h0;
        lat = 1;
        while (!ready_a && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_w_lat",   32'(lat), 32'd2);
        check("b2b_w_hold",  rdata_a,  32'hDEADBEEF);
        @(posedge clk); #1;
        req_a = 1'b0;
        check("b2b_accept",  32'(busy_a), 32'd1);
        lat = 1;
        while (!ready_a && lat < 20) begin @(posedge clk); #1; lat++; end
        check("b2b_r_lat",   32'(lat), 32'd2);
        check("b2b_r_data",  rdata_a,  32'h00001234);
        @(posedge clk); #1;

        // Misaligned write @0x13
        txn(0, 1'b1, 32'h13, 32'h55, rd, er, lat);
        check("mis_err", 32'(er),  32'(ERRCHK));
        check("mis_lat", 32'(lat), 32'd2);
        txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("mis_r10", rd, ERRCHK ? 32'hDEADBEEF : 32'h00000055);

        // Out-of-range write @0x1000
        txn(0, 1'b1, 32'h0, 32'h77, rd, er, lat);
        txn(0, 1'b1, 32'h1000, 32'hA5, rd, er, lat);
        check("wrap_err", 32'(er), 32'(ERRCHK));
        txn(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("wrap_r0", rd, ERRCHK ? 32'h00000077 : 32'h000000A5);

        // Reset in WAIT drops the write
        txn(0, 1'b1, 32'h40, 32'h11111111, rd, er, lat);
        txn(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check("pre_rst_r40", rd, 32'h11111111);
        @(negedge clk);
        req_a = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h22222222;
        @(posedge clk); #1;
        req_a = 1'b0;
        check("mid_busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready_a), 32'd0);
        check("mid_rst_busy",  32'(busy_a),  32'd0);
        check("mid_rst_rdata", rdata_a,      32'd0);
        @(negedge clk); rst = 1'b1;
        txn(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check("post_rst_r40", rd, 32'h11111111);

        check("b_busy_never", 32'(busy_b_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
